// File: rtl/smps_pkg.sv
// smps_pkg: shared state type and duty defaults for the sequencer, dpwm and soft_shutdown
package smps_pkg;
  localparam int TON_W = 11;
  localparam logic [TON_W-1:0] DUTY_MAX = 11'd900;
  localparam int SLEW_STEP = 8;
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SOFT_START = 3'd1,
    REGULATE   = 3'd2,
    SHUTDOWN   = 3'd3,
    FAULT      = 3'd4
  } seq_state_t;
endpackage

// File: rtl/smps_sequencer_duty_slew.sv
// duty_slew: clamps the compensator target and steps the current duty toward it
module duty_slew #(
  parameter int TON_W = smps_pkg::TON_W,
  parameter logic [TON_W-1:0] DUTY_MAX = smps_pkg::DUTY_MAX,
  parameter logic [TON_W-1:0] DUTY_MIN = '0,
  parameter int SLEW_STEP = smps_pkg::SLEW_STEP
) (
  input  logic [TON_W-1:0] i_cur,
  input  logic [9:0]       i_comp_d,
  input  logic             i_valid,
  input  logic             i_load,
  input  logic [TON_W-1:0] i_load_d,
  output logic [TON_W-1:0] o_next
);
  logic [TON_W-1:0] w_raw, w_tgt;
  logic [TON_W:0] w_diff, w_mag, w_step;
  always_comb begin
    w_raw = TON_W'(i_comp_d);
    w_tgt = w_raw > DUTY_MAX ? DUTY_MAX : w_raw < DUTY_MIN ? DUTY_MIN : w_raw;
    // one extra bit keeps the difference signed so neither end wraps
    w_diff = {1'b0, w_tgt} - {1'b0, i_cur};
    w_mag = w_diff[TON_W] ? -w_diff : w_diff;
    w_step = w_mag > (TON_W+1)'(SLEW_STEP) ? (TON_W+1)'(SLEW_STEP) : w_mag;
    o_next = i_load ? i_load_d :
             !i_valid ? i_cur :
             w_diff[TON_W] ? i_cur - w_step[TON_W-1:0] : i_cur + w_step[TON_W-1:0];
  end
endmodule

// File: rtl/smps_sequencer.sv
// smps_sequencer: phase FSM, duty-source mux and fault trip for the SMPS power stage.
// Fault protection (ADC compare, debounce, FAULT state) exists only with SMPS_FAULT_PROT_EN.
module smps_sequencer #(
  parameter int TON_W = smps_pkg::TON_W,
  parameter logic [TON_W-1:0] DUTY_MAX = smps_pkg::DUTY_MAX,
  parameter logic [TON_W-1:0] DUTY_MIN = '0,
  parameter int SLEW_STEP = smps_pkg::SLEW_STEP,
  parameter logic [12:0] I_LIMIT = 13'd3000,
  parameter logic [12:0] T_LIMIT = 13'd3500,
  parameter int FAULT_CNT = 4
) (
  input  logic             i_clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_clear,
  input  logic [TON_W-1:0] i_ss_ton,
  input  logic             i_ss_done,
  input  logic [9:0]       i_comp_d,
  input  logic             i_comp_valid,
  input  logic [TON_W-1:0] i_sd_ton,
  input  logic             i_sd_done,
  input  logic [12:0]      i_adc_i,
  input  logic [12:0]      i_adc_temp,
  input  logic             i_adc_valid,
  output logic [TON_W-1:0] o_ton,
  output logic             o_dpwm_en,
  output logic             o_ss_en,
  output logic             o_comp_en,
  output logic             o_sd_en,
  output logic             o_sd_load,
  output logic [2:0]       o_state,
  output logic             o_fault
);
  import smps_pkg::*;
  seq_state_t r_state, w_next;
  logic [TON_W-1:0] r_ton, w_ton, w_slew;
  logic r_dpwm_en, r_ss_en, r_comp_en, r_sd_en, r_sd_load, r_fault;
  logic w_dpwm_en, w_ss_en, w_comp_en, w_sd_en, w_sd_load, w_fault;
  logic w_trip, w_clear;
`ifdef SMPS_FAULT_PROT_EN
  localparam int CW = $clog2(FAULT_CNT + 1);
  logic [CW-1:0] r_cnt;
  logic w_over;
  assign w_over = i_adc_i > I_LIMIT || i_adc_temp > T_LIMIT;
  assign w_trip = i_adc_valid && w_over && r_cnt == CW'(FAULT_CNT - 1);
  assign w_clear = i_clear;
  always_ff @(posedge i_clk)
    if (reset) r_cnt <= '0;
    else if (i_adc_valid) r_cnt <= w_over && !w_trip ? r_cnt + 1'b1 : '0;
`else
  logic w_unused;
  assign w_unused = ^{i_adc_i, i_adc_temp, i_adc_valid, i_clear};
  assign w_trip = 1'b0;
  assign w_clear = 1'b0;
`endif
  duty_slew #(
    .TON_W(TON_W), .DUTY_MAX(DUTY_MAX), .DUTY_MIN(DUTY_MIN), .SLEW_STEP(SLEW_STEP)
  ) u_slew (
    .i_cur(r_ton), .i_comp_d(i_comp_d), .i_valid(i_comp_valid),
    .i_load(r_state != REGULATE), .i_load_d(r_ton), .o_next(w_slew)
  );
  always_comb begin
    w_next = w_trip ? FAULT :
             r_state == IDLE ? (i_start && !i_stop ? SOFT_START : IDLE) :
             r_state == SOFT_START ? (i_stop || !i_start ? SHUTDOWN : i_ss_done ? REGULATE : SOFT_START) :
             r_state == REGULATE ? (i_stop || !i_start ? SHUTDOWN : REGULATE) :
             r_state == SHUTDOWN ? (i_sd_done ? IDLE : SHUTDOWN) :
             r_state == FAULT ? (w_clear && !i_start ? IDLE : FAULT) : IDLE;
    w_dpwm_en = w_next == SOFT_START || w_next == REGULATE || w_next == SHUTDOWN;
    w_ss_en = w_next == SOFT_START;
    w_comp_en = w_next == REGULATE;
    // shutdown block captures the held duty before it starts driving its ramp
    w_sd_load = w_next == SHUTDOWN && r_state != SHUTDOWN;
    w_sd_en = w_next == SHUTDOWN && r_state == SHUTDOWN;
    w_fault = w_next == FAULT;
    w_ton = w_next == SOFT_START ? i_ss_ton :
            w_next == REGULATE ? w_slew :
            w_sd_en ? i_sd_ton :
            w_sd_load ? r_ton : '0;
  end
  always_ff @(posedge i_clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_ton <= '0;
      r_dpwm_en <= 1'b0;
      r_ss_en <= 1'b0;
      r_comp_en <= 1'b0;
      r_sd_en <= 1'b0;
      r_sd_load <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ton <= w_ton;
      r_dpwm_en <= w_dpwm_en;
      r_ss_en <= w_ss_en;
      r_comp_en <= w_comp_en;
      r_sd_en <= w_sd_en;
      r_sd_load <= w_sd_load;
      r_fault <= w_fault;
    end
  end
  assign o_ton = r_ton;
  assign o_dpwm_en = r_dpwm_en;
  assign o_ss_en = r_ss_en;
  assign o_comp_en = r_comp_en;
  assign o_sd_en = r_sd_en;
  assign o_sd_load = r_sd_load;
  assign o_state = r_state;
  assign o_fault = r_fault;
endmodule

// File: tb/tb_smps_sequencer.sv
// tb_smps_sequencer: randomized bench for smps_sequencer against a phase-level reference model
module tb_smps_sequencer;
  localparam int DMAX = 900;
  localparam int SLEW = 8;
  localparam int ILIM = 3000;
  localparam int TLIM = 3500;
  localparam int FC = 4;
`ifdef SMPS_FAULT_PROT_EN
  localparam bit FP = 1'b1;
`else
  localparam bit FP = 1'b0;
`endif
  logic i_clk, reset, i_start, i_stop, i_clear, i_ss_done, i_comp_valid, i_sd_done, i_adc_valid;
  logic [10:0] i_ss_ton, i_sd_ton, o_ton;
  logic [9:0] i_comp_d;
  logic [12:0] i_adc_i, i_adc_temp;
  logic o_dpwm_en, o_ss_en, o_comp_en, o_sd_en, o_sd_load, o_fault;
  logic [2:0] o_state;
  int total = 0, bad = 0;
  int m_st, m_ton, m_cnt;
  bit m_dp, m_ss, m_cp, m_sd, m_ld, m_ft;

  smps_sequencer dut (
    .i_clk(i_clk), .reset(reset), .i_start(i_start), .i_stop(i_stop), .i_clear(i_clear),
    .i_ss_ton(i_ss_ton), .i_ss_done(i_ss_done), .i_comp_d(i_comp_d), .i_comp_valid(i_comp_valid),
    .i_sd_ton(i_sd_ton), .i_sd_done(i_sd_done), .i_adc_i(i_adc_i), .i_adc_temp(i_adc_temp),
    .i_adc_valid(i_adc_valid), .o_ton(o_ton), .o_dpwm_en(o_dpwm_en), .o_ss_en(o_ss_en),
    .o_comp_en(o_comp_en), .o_sd_en(o_sd_en), .o_sd_load(o_sd_load), .o_state(o_state), .o_fault(o_fault)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [19:0] dut_vec();
    return {o_state, o_fault, o_dpwm_en, o_ss_en, o_comp_en, o_sd_en, o_sd_load, o_ton};
  endfunction

  function automatic logic [19:0] exp_vec();
    return {3'(m_st), m_ft, m_dp, m_ss, m_cp, m_sd, m_ld, 11'(m_ton)};
  endfunction

  // Phase-level model: decide the next phase from the rules, then what that phase drives
  task automatic model_step();
    int nst, tgt;
    bit over, trip;
    over = int'(i_adc_i) > ILIM || int'(i_adc_temp) > TLIM;
    trip = FP && i_adc_valid && over && (m_cnt + 1 >= FC);
    if (reset) begin
      m_st = 0; m_ton = 0; m_cnt = 0;
      {m_dp, m_ss, m_cp, m_sd, m_ld, m_ft} = '0;
      return;
    end
    if (FP && i_adc_valid) m_cnt = (over && !trip) ? m_cnt + 1 : 0;
    nst = m_st;
    if (trip) nst = 4;
    else if (m_st == 0) begin if (i_start && !i_stop) nst = 1; end
    else if (m_st == 1) begin if (i_stop || !i_start) nst = 3; else if (i_ss_done) nst = 2; end
    else if (m_st == 2) begin if (i_stop || !i_start) nst = 3; end
    else if (m_st == 3) begin if (i_sd_done) nst = 0; end
    else if (m_st == 4) begin if (FP && i_clear && !i_start) nst = 0; end
    {m_dp, m_ss, m_cp, m_sd, m_ld, m_ft} = '0;
    if (nst == 0) m_ton = 0;
    else if (nst == 1) begin m_dp = 1; m_ss = 1; m_ton = int'(i_ss_ton); end
    else if (nst == 2) begin
      m_dp = 1; m_cp = 1;
      if (m_st == 2 && i_comp_valid) begin
        tgt = int'(i_comp_d);
        if (tgt > DMAX) tgt = DMAX;
        if (tgt > m_ton) m_ton += (tgt - m_ton < SLEW) ? tgt - m_ton : SLEW;
        else m_ton -= (m_ton - tgt < SLEW) ? m_ton - tgt : SLEW;
      end
    end
    else if (nst == 3) begin
      m_dp = 1;
      if (m_st != 3) m_ld = 1;
      else begin m_sd = 1; m_ton = int'(i_sd_ton); end
    end
    else begin m_ton = 0; m_ft = 1; end
    m_st = nst;
  endtask

  task automatic cyc();
    model_step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic quiet();
    {reset, i_start, i_stop, i_clear, i_ss_done, i_comp_valid, i_sd_done, i_adc_valid} = '0;
    i_ss_ton = '0; i_sd_ton = '0; i_comp_d = '0; i_adc_i = 13'd100; i_adc_temp = 13'd100;
  endtask

  task automatic goto_reg();
    i_start = 1; i_stop = 0; i_ss_ton = 11'($urandom_range(0, 600));
    cyc();
    i_ss_done = 1;
    cyc();
    i_ss_done = 0;
  endtask

  task automatic test_reset();
    quiet();
    reset = 1; i_start = 1; i_ss_ton = 11'd77;
    cyc();
    total++;
    if (dut_vec() !== 20'd0) begin bad++; $display("FAIL reset got=%h exp=0", dut_vec()); end
    reset = 0; i_start = 0;
    cyc();
    total++;
    if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL reset_idle got=%h exp=%h", dut_vec(), exp_vec()); end
  endtask

  task automatic test_power_up();
    int ramp = 0;
    i_start = 1; i_ss_ton = 0;
    while (ramp < 400) begin
      cyc();
      total++;
      if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL power_up ramp=%0d got=%h exp=%h", ramp, dut_vec(), exp_vec()); end
      ramp += $urandom_range(1, 25);
      if (ramp > 400) ramp = 400;
      i_ss_ton = 11'(ramp);
    end
    cyc();
    i_ss_done = 1;
    cyc();
    i_ss_done = 0;
    total++;
    if (o_state !== 3'd2 || o_ton !== 11'd400) begin bad++; $display("FAIL enter_regulate state=%0d ton=%0d exp 2/400", o_state, o_ton); end
    i_ss_ton = 11'($urandom_range(0, 2047));
    for (int k = 0; k < 3; k++) begin
      cyc();
      total++;
      if (dut_vec() !== exp_vec() || o_ton !== 11'd400) begin bad++; $display("FAIL hold400 got=%h exp=%h", dut_vec(), exp_vec()); end
    end
  endtask

  task automatic test_slew_clamp();
    i_comp_d = 10'd396; i_comp_valid = 1;
    cyc();
    i_comp_valid = 0;
    total++;
    if (o_ton !== 11'd396) begin bad++; $display("FAIL small_step got=%0d exp=396", o_ton); end
    i_comp_d = 10'd1000;
    for (int k = 0; k < 70; k++) begin
      i_comp_valid = 1;
      cyc();
      i_comp_valid = 0;
      total++;
      if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL slew_up k=%0d got=%h exp=%h", k, dut_vec(), exp_vec()); end
      repeat ($urandom_range(0, 2)) cyc();
    end
    total++;
    if (o_ton !== 11'd900) begin bad++; $display("FAIL clamp got=%0d exp=900", o_ton); end
    for (int k = 0; k < 30; k++) begin
      i_comp_d = 10'($urandom_range(0, 1023)); i_comp_valid = 1'($urandom_range(0, 1));
      cyc();
      total++;
      if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL slew_rand k=%0d got=%h exp=%h", k, dut_vec(), exp_vec()); end
    end
    i_comp_valid = 0;
  endtask

  task automatic test_shutdown();
    int sd = 500;
    i_comp_d = 10'd500;
    for (int k = 0; k < 200 && m_ton != 500; k++) begin
      i_comp_valid = 1;
      cyc();
    end
    i_comp_valid = 0;
    cyc();
    total++;
    if (o_ton !== 11'd500 || o_state !== 3'd2) begin bad++; $display("FAIL reach500 ton=%0d state=%0d", o_ton, o_state); end
    i_stop = 1; i_sd_ton = 11'd123;
    cyc();
    total++;
    if (o_sd_load !== 1'b1 || o_ton !== 11'd500 || o_state !== 3'd3 || o_sd_en !== 1'b0)
      begin bad++; $display("FAIL sd_entry load=%b ton=%0d state=%0d sd_en=%b", o_sd_load, o_ton, o_state, o_sd_en); end
    for (int k = 0; k < 8; k++) begin
      i_stop = 1'($urandom_range(0, 1)); i_start = 1'($urandom_range(0, 1));
      sd -= $urandom_range(10, 60);
      i_sd_ton = 11'(sd);
      cyc();
      total++;
      if (dut_vec() !== exp_vec() || o_sd_load !== 1'b0) begin bad++; $display("FAIL sd_follow k=%0d got=%h exp=%h", k, dut_vec(), exp_vec()); end
    end
    i_start = 0; i_stop = 0; i_sd_done = 1;
    cyc();
    i_sd_done = 0;
    total++;
    if (o_state !== 3'd0 || o_dpwm_en !== 1'b0 || o_ton !== 11'd0) begin bad++; $display("FAIL sd_done state=%0d dpwm=%b ton=%0d", o_state, o_dpwm_en, o_ton); end
  endtask

  task automatic test_simultaneous();
    i_start = 1; i_ss_ton = 11'd50;
    cyc();
    i_ss_done = 1; i_stop = 1;
    cyc();
    i_ss_done = 0;
    total++;
    if (o_state !== 3'd3 || dut_vec() !== exp_vec()) begin bad++; $display("FAIL stop_over_done state=%0d got=%h exp=%h", o_state, dut_vec(), exp_vec()); end
    i_stop = 0; i_start = 0; i_sd_done = 1;
    cyc();
    i_sd_done = 0;
  endtask

  task automatic adc_strobe(input bit over_s);
    bit use_t = 1'($urandom_range(0, 1));
    i_adc_valid = 1;
    i_adc_i = over_s && !use_t ? 13'd3100 : 13'($urandom_range(0, 3000));
    i_adc_temp = over_s && use_t ? 13'($urandom_range(3501, 4000)) : 13'($urandom_range(0, 3500));
    cyc();
    i_adc_valid = 0;
  endtask

`ifdef SMPS_FAULT_PROT_EN
  task automatic test_fault();
    goto_reg();
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < 3; k++) begin
        adc_strobe(1);
        repeat ($urandom_range(0, 2)) cyc();
      end
      adc_strobe(0);
    end
    total++;
    if (o_fault !== 1'b0 || o_state !== 3'd2) begin bad++; $display("FAIL burst3 fault=%b state=%0d exp 0/2", o_fault, o_state); end
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(0, 2)) cyc();
      adc_strobe(1);
    end
    total++;
    if (o_fault !== 1'b1 || o_dpwm_en !== 1'b0 || o_state !== 3'd4 || o_ton !== 11'd0)
      begin bad++; $display("FAIL trip fault=%b dpwm=%b state=%0d ton=%0d", o_fault, o_dpwm_en, o_state, o_ton); end
    i_clear = 1;
    cyc();
    i_clear = 0;
    total++;
    if (o_state !== 3'd4 || o_fault !== 1'b1) begin bad++; $display("FAIL clear_with_start state=%0d exp 4", o_state); end
    i_start = 0; i_clear = 1;
    cyc();
    i_clear = 0;
    total++;
    if (o_state !== 3'd0 || o_fault !== 1'b0) begin bad++; $display("FAIL clear state=%0d fault=%b exp 0/0", o_state, o_fault); end
  endtask
`else
  task automatic test_fault();
    goto_reg();
    for (int k = 0; k < 6; k++) adc_strobe(1);
    i_clear = 1;
    cyc();
    i_clear = 0;
    total++;
    if (o_fault !== 1'b0 || o_state !== 3'd2) begin bad++; $display("FAIL no_prot fault=%b state=%0d exp 0/2", o_fault, o_state); end
    i_start = 0; i_sd_done = 1;
    cyc();
    i_sd_done = 0;
    cyc();
  endtask
`endif

  task automatic test_reset_mid();
    goto_reg();
    i_comp_d = 10'd700; i_comp_valid = 1;
    repeat (3) cyc();
    i_comp_valid = 0;
    reset = 1;
    cyc();
    reset = 0;
    total++;
    if (dut_vec() !== 20'd0 || dut_vec() !== exp_vec()) begin bad++; $display("FAIL reset_mid got=%h exp=0", dut_vec()); end
    i_start = 0;
    cyc();
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      reset = $urandom_range(0, 299) == 0;
      if ($urandom_range(0, 39) == 0) i_start = ~i_start;
      if ($urandom_range(0, 59) == 0) i_stop = ~i_stop;
      i_clear = $urandom_range(0, 9) == 0;
      i_ss_done = $urandom_range(0, 19) == 0;
      i_sd_done = $urandom_range(0, 14) == 0;
      i_comp_valid = $urandom_range(0, 2) == 0;
      i_comp_d = 10'($urandom_range(0, 1023));
      i_ss_ton = 11'($urandom_range(0, 2047));
      i_sd_ton = 11'($urandom_range(0, 2047));
      i_adc_valid = $urandom_range(0, 3) == 0;
      i_adc_i = 13'($urandom_range(2850, 3100));
      i_adc_temp = 13'($urandom_range(3300, 3520));
      cyc();
      total++;
      if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL random k=%0d got=%h exp=%h", k, dut_vec(), exp_vec()); end
    end
  endtask

  initial begin
    m_st = 0; m_ton = 0; m_cnt = 0;
    {m_dp, m_ss, m_cp, m_sd, m_ld, m_ft} = '0;
    test_reset();
    test_power_up();
    test_slew_clamp();
    test_shutdown();
    test_simultaneous();
    test_fault();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
